pipe_ctrl: RTL

//  Parametrised pipeline controller for the in-order core. Owns per-stage valid bits and

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake, hazard/flush request and redirect bundle between pipe_ctrl and the core datapath.
// master = the controller (pipe_ctrl), slave = the datapath/fetch side that raises requests.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                             in_valid;
  logic                             out_ready;
  logic [NUM_STAGES-1:0]            stage_busy;
  logic [NUM_STAGES-1:0]            stage_stall;
  logic [NUM_STAGES-1:0]            flush_req;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] flush_target;
  logic                             exp_en;
  logic                             e_ret;
  logic [ADDR_WIDTH-1:0]            trap_entry;
  logic [ADDR_WIDTH-1:0]            epc;
  logic [NUM_STAGES-1:0]            stage_valid;
  logic [NUM_STAGES-1:0]            stage_allowin;
  logic [NUM_STAGES-1:0]            flush_out;
  logic                             in_ready;
  logic                             redirect_valid;
  logic [ADDR_WIDTH-1:0]            redirect_pc;
  logic [CNT_WIDTH-1:0]             retire_cnt;
  logic [CNT_WIDTH-1:0]             flush_cnt;

  modport master (
    input  in_valid, out_ready, stage_busy, stage_stall, flush_req, flush_target,
           exp_en, e_ret, trap_entry, epc,
    output stage_valid, stage_allowin, flush_out, in_ready, redirect_valid, redirect_pc,
           retire_cnt, flush_cnt
  );

  modport slave (
    output in_valid, out_ready, stage_busy, stage_stall, flush_req, flush_target,
           exp_en, e_ret, trap_entry, epc,
    input  stage_valid, stage_allowin, flush_out, in_ready, redirect_valid, redirect_pc,
           retire_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: stage valids, allowin ripple, one-winner kill mask, registered redirect.
// Kill mask and allowin are same-cycle; redirect lands one cycle later; out_ready=0 backs up the whole pipe.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int EXC_STAGE  = 3,
  parameter int CNT_WIDTH  = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);
  localparam int N = NUM_STAGES;

  logic [N-1:0]          v;
  logic [N-1:0]          v_nxt;
  logic [N-1:0]          ready_go;
  logic [N-1:0]          allowin;
  logic [N-1:0]          kill;
  logic [N-1:0]          flush_q;
  logic                  exc_hit;
  logic                  eret_hit;
  logic                  accept;
  logic                  retire;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]  retire_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  function automatic logic [N-1:0] low_mask(input int upto);
    logic [N-1:0] m;
    for (int j = 0; j < N; j++) m[j] = (j < upto);
    return m;
  endfunction

  assign ready_go = v & ~bus.stage_busy & ~bus.stage_stall;

  always_comb begin
    allowin      = '0;
    allowin[N-1] = ~v[N-1] | (ready_go[N-1] & bus.out_ready);
    for (int i = N - 2; i >= 0; i--) begin
      allowin[i] = ~v[i] | (ready_go[i] & allowin[i+1]);
    end
  end

  assign exc_hit  = bus.exp_en & v[EXC_STAGE];
  assign eret_hit = bus.e_ret & v[EXC_STAGE];
  assign flush_q  = bus.flush_req & v;

  // Ascending scan: the oldest (highest-index) flush request is the last one written and wins.
  always_comb begin
    accept = 1'b0;
    kill   = '0;
    target = '0;
    if (exc_hit) begin
      accept = 1'b1;
      kill   = low_mask(EXC_STAGE + 1);
      target = bus.trap_entry;
    end else if (eret_hit) begin
      accept = 1'b1;
      kill   = low_mask(EXC_STAGE + 1);
      target = bus.epc;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (flush_q[k]) begin
          accept = 1'b1;
          kill   = low_mask(k);
          target = bus.flush_target[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  // A killed instruction must not ride into the next stage, so the source kill bit gates the transfer.
  always_comb begin
    v_nxt    = '0;
    v_nxt[0] = (allowin[0] ? (bus.in_valid & ~redirect_valid) : v[0]) & ~kill[0];
    for (int i = 1; i < N; i++) begin
      v_nxt[i] = (allowin[i] ? (ready_go[i-1] & ~kill[i-1]) : v[i]) & ~kill[i];
    end
  end

  assign retire = ready_go[N-1] & bus.out_ready & ~kill[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v              <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retire_cnt     <= '0;
      flush_cnt      <= '0;
    end else begin
      v              <= v_nxt;
      redirect_valid <= accept;
      if (accept) begin
        redirect_pc <= target;
        flush_cnt   <= flush_cnt + CNT_WIDTH'(1);
      end
      if (retire) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.stage_valid    = v;
  assign bus.stage_allowin  = allowin;
  assign bus.flush_out      = kill;
  assign bus.in_ready       = allowin[0] & ~redirect_valid;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.retire_cnt     = retire_cnt;
  assign bus.flush_cnt      = flush_cnt;
endmodule
